mod_mul_ctrl: RTL and testbench
===============================

MOD_MUL_CTRL -- requirements
Module: mod_mul_ctrl

Interface
REQ-001 Parameter NBITS, default 128: operand/modulus width in bits.
REQ-002 Parameter PBITS, default 2: headroom bits of the mx3 bus.
REQ-003 Parameter TAGW, default 4: request tag width in bits.
REQ-004 Parameter TMO, default NBITS/2+8: maximum number of WAIT cycles before timeout.
REQ-005 Ports: clk in 1, sole clock, rising edge.
REQ-006 Ports: rst in 1, reset, asynchronous, active-high.
REQ-007 Ports: req_valid in 1 / req_ready out 1, request handshake.
REQ-008 Ports: req_a, req_b, req_m in NBITS each, operands and modulus; req_tag in TAGW.
REQ-009 Ports: mul_enable_p out 1, start pulse to the multiplier.
REQ-010 Ports: mul_a, mul_b, mul_m out NBITS each, multiplier operands; mul_mx3 out NBITS+PBITS, equal to 3*m.
REQ-011 Ports: mul_y in NBITS, multiplier result; mul_done_p in 1, one-cycle completion pulse.
REQ-012 Ports: rsp_valid out 1 / rsp_ready in 1, response handshake; rsp_y out NBITS; rsp_tag out TAGW.
REQ-013 Ports: err_tmo out 1, sticky timeout flag; err_clr in 1, clears err_tmo.

Function
REQ-014 Request transfer occurs when req_valid and req_ready are both high on a rising clk edge; the response transfer uses rsp_valid/rsp_ready the same way.
REQ-015 FSM states: IDLE, PREP, LAUNCH, WAIT.
- IDLE->PREP on a request transfer.
- PREP->LAUNCH after 1 cycle.
- LAUNCH->WAIT after 1 cycle.
- WAIT->IDLE on mul_done_p or on timeout.
REQ-016 req_ready is high only in IDLE with fewer than 2 entries in the response buffer.
REQ-017 On transfer, a, b, m and tag are registered. mul_a, mul_b and mul_m present the registered values and hold them until the next transfer.
REQ-018 mx3 is computed in PREP as (m<<1)+m, full width NBITS+PBITS without truncation. It is registered and drives mul_mx3.
REQ-019 mul_enable_p is high for exactly the one LAUNCH cycle and low in every other cycle.
REQ-020 Cycle count: transfer at cycle t, PREP at t+1, mul_enable_p at t+2, WAIT from t+3.
REQ-021 On mul_done_p in WAIT, {mul_y, tag} is written to the response buffer that cycle; rsp_valid is high from the next cycle.
REQ-022 mul_done_p outside WAIT is ignored; no buffer write.
REQ-023 WAIT cycle counter: cleared on entering WAIT. If it reaches TMO without mul_done_p, then err_tmo<=1, return to IDLE, no buffer write.
REQ-024 err_clr clears err_tmo. If timeout and err_clr occur in the same cycle, set wins.
REQ-025 Response buffer: 2-entry FIFO, in-order. Head drives rsp_y/rsp_tag; rsp_y/rsp_tag hold stable while rsp_valid is high and rsp_ready is low.
REQ-026 A buffer write and a pop in the same cycle on a full buffer are legal. Count is unchanged and ordering is preserved.
REQ-027 Back-pressure: req_ready is held low while the buffer is full.
REQ-028 Results are not reduced further: rsp_y = mul_y bit-exact.

Reset
REQ-029 On rst assertion, asynchronously:
- FSM goes to IDLE.
- mul_enable_p=0, rsp_valid=0, err_tmo=0, buffer emptied.
- All operand/mx3/tag/counter registers go to 0.
- req_ready goes to 0 while rst is high and to 1 on the first cycle after deassertion.
REQ-030 rst during WAIT discards the in-flight operation. A later mul_done_p after reset is ignored per REQ-022.

Structure
REQ-031 FSM state encoding and the buffer-depth constant (2) reside in the shared multpool package.
REQ-032 The response buffer is one sub-module, mod_mul_rsp_fifo (parameterised width NBITS+TAGW, depth 2); the FSM, mx3 generation and timeout counter sit in the top level.

Verification
REQ-033 Use NBITS=16 with a behavioural multiplier model of configurable latency in all scenarios below.
REQ-034 Basic: a=3, b=5, m=7, tag=2 -> mul_mx3=21; mul_enable_p 2 cycles after transfer; rsp_y=1, rsp_tag=2.
REQ-035 Back-pressure: 3 back-to-back requests with rsp_ready=0 -> req_ready low after 2 results are buffered; release -> results in order, third accepted.
REQ-036 Max modulus: m=0xFFFF -> mul_mx3=0x2FFFD (no truncation).
REQ-037 Timeout: model never pulses done -> err_tmo=1 after TMO WAIT cycles, FSM in IDLE, rsp_valid stays 0; err_clr -> 0.
REQ-038 Reset mid-WAIT: assert rst, then the model pulses done -> no response, buffer empty, next request a=2, b=2, m=5 returns 4.

Source files
------------

// File: rtl/mod_mul_ctrl_pkg.sv
// Shared multpool package for the modular-multiplier controller.
// Holds the controller FSM state encoding and the response-buffer depth so the
// top level and the response FIFO agree on them.
package mod_mul_ctrl_pkg;

    // Response buffer depth; also the back-pressure threshold for new requests.
    localparam int unsigned RspDepth = 2;

    typedef enum logic [1:0] {
        StIdle,
        StPrep,
        StLaunch,
        StWait
    } ctrl_state_e;

endpackage

// File: rtl/mod_mul_ctrl_if.sv
// Bus bundle for mod_mul_ctrl: request handshake, multiplier launch/result,
// response handshake and the sticky timeout flag.
//   slave  : controller side (accepts requests, drives the multiplier, returns responses)
//   master : requester/multiplier side (testbench or surrounding fabric)
interface mod_mul_ctrl_if #(
    parameter int unsigned NBITS = 128,
    parameter int unsigned PBITS = 2,
    parameter int unsigned TAGW  = 4
) ();

    logic                   req_valid;
    logic                   req_ready;
    logic [NBITS-1:0]       req_a;
    logic [NBITS-1:0]       req_b;
    logic [NBITS-1:0]       req_m;
    logic [TAGW-1:0]        req_tag;

    logic                   mul_enable_p;
    logic [NBITS-1:0]       mul_a;
    logic [NBITS-1:0]       mul_b;
    logic [NBITS-1:0]       mul_m;
    logic [NBITS+PBITS-1:0] mul_mx3;
    logic [NBITS-1:0]       mul_y;
    logic                   mul_done_p;

    logic                   rsp_valid;
    logic                   rsp_ready;
    logic [NBITS-1:0]       rsp_y;
    logic [TAGW-1:0]        rsp_tag;

    logic                   err_tmo;
    logic                   err_clr;

    modport slave (
        input  req_valid, req_a, req_b, req_m, req_tag,
        output req_ready,
        output mul_enable_p, mul_a, mul_b, mul_m, mul_mx3,
        input  mul_y, mul_done_p,
        output rsp_valid, rsp_y, rsp_tag,
        input  rsp_ready,
        output err_tmo,
        input  err_clr
    );

    modport master (
        output req_valid, req_a, req_b, req_m, req_tag,
        input  req_ready,
        input  mul_enable_p, mul_a, mul_b, mul_m, mul_mx3,
        output mul_y, mul_done_p,
        input  rsp_valid, rsp_y, rsp_tag,
        output rsp_ready,
        input  err_tmo,
        output err_clr
    );

endinterface

// File: rtl/mod_mul_rsp_fifo.sv
// In-order response buffer for mod_mul_ctrl.
// Ports:
//   clk, rst     : clock, asynchronous active-high reset (empties the buffer)
//   wr_en_i      : write request; accepted when not full, or when full with a pop that cycle
//   wr_data_i    : entry to write
//   rd_en_i      : consumer ready; pops the head when valid_o is high
//   rd_data_o    : head entry, stable until popped
//   valid_o      : buffer non-empty
//   full_o       : buffer holds Depth entries
module mod_mul_rsp_fifo
    import mod_mul_ctrl_pkg::*;
#(
    parameter int unsigned Width = 8,
    parameter int unsigned Depth = RspDepth
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en_i,
    input  logic [Width-1:0] wr_data_i,
    input  logic             rd_en_i,
    output logic [Width-1:0] rd_data_o,
    output logic             valid_o,
    output logic             full_o
);

    localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1;
    localparam int unsigned CntW = $clog2(Depth + 1);

    logic [Width-1:0] mem_q [Depth];
    logic [PtrW-1:0]  wptr_q, rptr_q;
    logic [CntW-1:0]  cnt_q;
    logic             push, pop;

    function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
        return (p == PtrW'(Depth - 1)) ? '0 : p + PtrW'(1);
    endfunction

    assign valid_o   = (cnt_q != '0);
    assign full_o    = (cnt_q == CntW'(Depth));
    assign pop       = rd_en_i && valid_o;
    // A write into a full buffer is only taken when the head leaves in the same cycle.
    assign push      = wr_en_i && (!full_o || pop);
    assign rd_data_o = mem_q[rptr_q];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr_q <= '0;
            rptr_q <= '0;
            cnt_q  <= '0;
            for (int i = 0; i < int'(Depth); i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            if (push) begin
                mem_q[wptr_q] <= wr_data_i;
                wptr_q        <= ptr_inc(wptr_q);
            end
            if (pop) begin
                rptr_q <= ptr_inc(rptr_q);
            end
            if (push && !pop) begin
                cnt_q <= cnt_q + CntW'(1);
            end else if (pop && !push) begin
                cnt_q <= cnt_q - CntW'(1);
            end
        end
    end

endmodule

// File: rtl/mod_mul_ctrl.sv
// Modular-multiplier controller: accepts a request (a, b, m, tag), precomputes
// 3*m, pulses the external multiplier for one cycle, waits for its completion
// pulse (bounded by TMO cycles) and queues {y, tag} into a 2-entry response FIFO.
// Ports:
//   clk, rst : clock, asynchronous active-high reset
//   bus      : mod_mul_ctrl_if.slave (request, multiplier, response, error flag)
module mod_mul_ctrl
    import mod_mul_ctrl_pkg::*;
#(
    parameter int unsigned NBITS = 128,
    parameter int unsigned PBITS = 2,
    parameter int unsigned TAGW  = 4,
    parameter int unsigned TMO   = NBITS / 2 + 8
) (
    input  logic            clk,
    input  logic            rst,
    mod_mul_ctrl_if.slave   bus
);

    localparam int unsigned MxW  = NBITS + PBITS;
    localparam int unsigned CntW = $clog2(TMO + 1);

    ctrl_state_e      state_q;
    logic [NBITS-1:0] a_q, b_q, m_q;
    logic [TAGW-1:0]  tag_q;
    logic [MxW-1:0]   mx3_q;
    logic [CntW-1:0]  cnt_q;
    logic             mul_en_q;
    logic             err_q;

    logic [MxW-1:0]   m_ext, mx3_d;
    logic             req_ready, req_fire;
    logic             fifo_wr, fifo_full, fifo_valid;
    logic             tmo_hit;
    logic [NBITS+TAGW-1:0] fifo_rd;

    // 3*m at full width so the top bits of a maximal modulus survive.
    assign m_ext = MxW'(m_q);
    assign mx3_d = (m_ext << 1) + m_ext;

    // Gated by rst so the request side is closed while reset is held.
    assign req_ready = (state_q == StIdle) && !fifo_full && !rst;
    assign req_fire  = bus.req_valid && req_ready;
    assign fifo_wr   = (state_q == StWait) && bus.mul_done_p;
    // A done pulse in the last allowed cycle still counts as completion.
    assign tmo_hit   = (state_q == StWait) && !bus.mul_done_p && (cnt_q == CntW'(TMO - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= StIdle;
            a_q      <= '0;
            b_q      <= '0;
            m_q      <= '0;
            tag_q    <= '0;
            mx3_q    <= '0;
            cnt_q    <= '0;
            mul_en_q <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (req_fire) begin
                        a_q     <= bus.req_a;
                        b_q     <= bus.req_b;
                        m_q     <= bus.req_m;
                        tag_q   <= bus.req_tag;
                        state_q <= StPrep;
                    end
                end
                StPrep: begin
                    mx3_q    <= mx3_d;
                    mul_en_q <= 1'b1;
                    state_q  <= StLaunch;
                end
                StLaunch: begin
                    mul_en_q <= 1'b0;
                    cnt_q    <= '0;
                    state_q  <= StWait;
                end
                StWait: begin
                    if (fifo_wr || tmo_hit) begin
                        state_q <= StIdle;
                    end else begin
                        cnt_q <= cnt_q + CntW'(1);
                    end
                end
                default: state_q <= StIdle;
            endcase

            // Set has priority over clear.
            if (tmo_hit) begin
                err_q <= 1'b1;
            end else if (bus.err_clr) begin
                err_q <= 1'b0;
            end
        end
    end

    mod_mul_rsp_fifo #(
        .Width (NBITS + TAGW),
        .Depth (RspDepth)
    ) u_rsp_fifo (
        .clk       (clk),
        .rst       (rst),
        .wr_en_i   (fifo_wr),
        .wr_data_i ({bus.mul_y, tag_q}),
        .rd_en_i   (bus.rsp_ready),
        .rd_data_o (fifo_rd),
        .valid_o   (fifo_valid),
        .full_o    (fifo_full)
    );

    assign bus.req_ready    = req_ready;
    assign bus.mul_enable_p = mul_en_q;
    assign bus.mul_a        = a_q;
    assign bus.mul_b        = b_q;
    assign bus.mul_m        = m_q;
    assign bus.mul_mx3      = mx3_q;
    assign bus.rsp_valid    = fifo_valid;
    assign bus.rsp_y        = fifo_rd[TAGW +: NBITS];
    assign bus.rsp_tag      = fifo_rd[TAGW-1:0];
    assign bus.err_tmo      = err_q;

endmodule

// File: tb/tb_mod_mul_ctrl.sv
// Directed self-checking bench for mod_mul_ctrl (NBITS=16) with a behavioural
// multiplier of configurable latency and a response scoreboard.
module tb_mod_mul_ctrl;

    localparam int unsigned NB  = 16;
    localparam int unsigned PB  = 2;
    localparam int unsigned TW  = 4;
    localparam int unsigned TMO = NB / 2 + 8;

    logic clk = 1'b0;
    logic rst;

    int n_cmp = 0;
    int n_err = 0;

    // Multiplier model controls and state.
    int             lat  = 1;
    bit             mute = 1'b0;
    int             m_cnt = 0;
    bit             m_busy = 1'b0;
    logic [NB-1:0]  m_res = '0;

    logic [NB+TW-1:0] exp_q[$];
    logic [NB+TW-1:0] mon_e;
    bit               seen;

    mod_mul_ctrl_if #(.NBITS(NB), .PBITS(PB), .TAGW(TW)) bus ();

    mod_mul_ctrl #(
        .NBITS (NB),
        .PBITS (PB),
        .TAGW  (TW),
        .TMO   (TMO)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [NB-1:0] modmul(input logic [NB-1:0] a, b, m);
        if (m == '0) return '0;
        return NB'((64'(a) * 64'(b)) % 64'(m));
    endfunction

    // Behavioural multiplier: latches operands on the enable pulse and returns
    // a*b mod m as a one-cycle done pulse `lat` cycles later (unless muted).
    initial begin
        bus.mul_done_p = 1'b0;
        bus.mul_y      = '0;
        forever begin
            @(posedge clk);
            #1;
            bus.mul_done_p = 1'b0;
            if (m_busy) begin
                if (m_cnt == 0) begin
                    m_busy = 1'b0;
                    if (!mute) begin
                        bus.mul_done_p = 1'b1;
                        bus.mul_y      = m_res;
                    end
                end else begin
                    m_cnt--;
                end
            end
            if (bus.mul_enable_p === 1'b1) begin
                m_busy = 1'b1;
                m_cnt  = lat - 1;
                m_res  = modmul(bus.mul_a, bus.mul_b, bus.mul_m);
            end
        end
    end

    // Response monitor: a transfer happens at the next rising edge.
    always @(negedge clk) begin
        if (rst === 1'b0 && bus.rsp_valid === 1'b1 && bus.rsp_ready === 1'b1) begin
            if (exp_q.size() == 0) begin
                check("rsp_unexpected", 64'd1, 64'd0);
            end else begin
                mon_e = exp_q.pop_front();
                check("rsp_y", 64'(bus.rsp_y), 64'(mon_e[TW +: NB]));
                check("rsp_tag", 64'(bus.rsp_tag), 64'(mon_e[TW-1:0]));
            end
        end
    end

    task automatic drive_req(input logic [NB-1:0] a, b, m, input logic [TW-1:0] tag,
                             input bit expect_rsp);
        bus.req_a     = a;
        bus.req_b     = b;
        bus.req_m     = m;
        bus.req_tag   = tag;
        bus.req_valid = 1'b1;
        if (expect_rsp) exp_q.push_back({modmul(a, b, m), tag});
    endtask

    // Returns just after the accepting edge (or after the budget expires).
    task automatic wait_accept(input string tag);
        bit ok = 1'b0;
        for (int i = 0; i < 200 && !ok; i++) begin
            @(negedge clk);
            ok = (bus.req_ready === 1'b1);
            @(posedge clk);
        end
        #1;
        bus.req_valid = 1'b0;
        check(tag, 64'(ok), 64'd1);
    endtask

    task automatic wait_drain(input string tag);
        for (int i = 0; i < 100 && exp_q.size() != 0; i++) @(negedge clk);
        @(negedge clk);
        check(tag, 64'(exp_q.size()), 64'd0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: observed no finish, expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst           = 1'b0;
        bus.req_valid = 1'b0;
        bus.req_a     = '0;
        bus.req_b     = '0;
        bus.req_m     = '0;
        bus.req_tag   = '0;
        bus.rsp_ready = 1'b1;
        bus.err_clr   = 1'b0;
        #2 rst = 1'b1;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_req_ready", 64'(bus.req_ready), 64'd0);
        check("rst_rsp_valid", 64'(bus.rsp_valid), 64'd0);
        check("rst_mul_en", 64'(bus.mul_enable_p), 64'd0);
        check("rst_err", 64'(bus.err_tmo), 64'd0);
        check("rst_mx3", 64'(bus.mul_mx3), 64'd0);
        @(negedge clk) rst = 1'b0;
        @(negedge clk);
        check("ready_after_rst", 64'(bus.req_ready), 64'd1);
        @(posedge clk);
        #1;

        // Basic: 3*5 mod 7 = 1, enable two cycles after transfer, mx3 = 21
        lat = 3;
        drive_req(16'd3, 16'd5, 16'd7, 4'd2, 1'b1);
        wait_accept("acc_basic");
        @(negedge clk);
        check("prep_en", 64'(bus.mul_enable_p), 64'd0);
        check("prep_ready", 64'(bus.req_ready), 64'd0);
        @(negedge clk);
        check("launch_en", 64'(bus.mul_enable_p), 64'd1);
        check("mx3_basic", 64'(bus.mul_mx3), 64'd21);
        check("mul_a", 64'(bus.mul_a), 64'd3);
        check("mul_b", 64'(bus.mul_b), 64'd5);
        check("mul_m", 64'(bus.mul_m), 64'd7);
        @(negedge clk);
        check("wait_en", 64'(bus.mul_enable_p), 64'd0);
        wait_drain("drain_basic");

        // Back-pressure: two results fill the buffer, third request is held off
        bus.rsp_ready = 1'b0;
        lat = 2;
        drive_req(16'd11, 16'd13, 16'd17, 4'd1, 1'b1);
        wait_accept("acc_bp1");
        drive_req(16'd100, 16'd200, 16'd251, 4'd3, 1'b1);
        wait_accept("acc_bp2");
        drive_req(16'd7, 16'd8, 16'd9, 4'd4, 1'b1);
        seen = 1'b0;
        repeat (12) begin
            @(negedge clk);
            if (bus.req_ready === 1'b1) seen = 1'b1;
        end
        check("bp_ready_low", 64'(seen), 64'd0);
        check("bp_rsp_valid", 64'(bus.rsp_valid), 64'd1);
        check("bp_head_y", 64'(bus.rsp_y), 64'd7);
        check("bp_head_tag", 64'(bus.rsp_tag), 64'd1);
        @(negedge clk);
        check("bp_hold_y", 64'(bus.rsp_y), 64'd7);
        @(posedge clk);
        #1;
        bus.rsp_ready = 1'b1;
        wait_accept("acc_bp3");
        wait_drain("drain_bp");

        // Max modulus: 3*0xFFFF without truncation
        drive_req(16'hFFFE, 16'hFFFD, 16'hFFFF, 4'hA, 1'b1);
        wait_accept("acc_max");
        repeat (2) @(negedge clk);
        check("mx3_max", 64'(bus.mul_mx3), 64'h2FFFD);
        wait_drain("drain_max");

        // Timeout: no done pulse
        mute = 1'b1;
        drive_req(16'd5, 16'd6, 16'd7, 4'd1, 1'b0);
        wait_accept("acc_tmo");
        repeat (2 + TMO) @(negedge clk);
        check("tmo_not_yet", 64'(bus.err_tmo), 64'd0);
        check("tmo_busy", 64'(bus.req_ready), 64'd0);
        @(negedge clk);
        check("tmo_err", 64'(bus.err_tmo), 64'd1);
        check("tmo_idle", 64'(bus.req_ready), 64'd1);
        check("tmo_no_rsp", 64'(bus.rsp_valid), 64'd0);
        repeat (3) @(negedge clk);
        check("tmo_sticky", 64'(bus.err_tmo), 64'd1);
        @(posedge clk);
        #1 bus.err_clr = 1'b1;
        @(posedge clk);
        #1 bus.err_clr = 1'b0;
        @(negedge clk);
        check("tmo_clr", 64'(bus.err_tmo), 64'd0);

        // Timeout with err_clr held: set wins
        @(posedge clk);
        #1 bus.err_clr = 1'b1;
        drive_req(16'd5, 16'd6, 16'd7, 4'd2, 1'b0);
        wait_accept("acc_tmo2");
        repeat (3 + TMO) @(negedge clk);
        check("tmo_set_wins", 64'(bus.err_tmo), 64'd1);
        @(posedge clk);
        #1 bus.err_clr = 1'b0;
        @(negedge clk);
        check("tmo_clr2", 64'(bus.err_tmo), 64'd0);
        @(posedge clk);
        #1;

        // Reset mid-WAIT: late done must be ignored
        mute = 1'b0;
        lat  = 6;
        drive_req(16'd9, 16'd9, 16'd11, 4'd5, 1'b0);
        wait_accept("acc_rstw");
        repeat (4) @(negedge clk);
        rst = 1'b1;
        #1;
        check("rstw_ready", 64'(bus.req_ready), 64'd0);
        check("rstw_en", 64'(bus.mul_enable_p), 64'd0);
        check("rstw_mul_a", 64'(bus.mul_a), 64'd0);
        @(negedge clk) rst = 1'b0;
        seen = 1'b0;
        repeat (12) begin
            @(negedge clk);
            if (bus.rsp_valid === 1'b1) seen = 1'b1;
        end
        check("rstw_no_rsp", 64'(seen), 64'd0);
        check("rstw_ready_back", 64'(bus.req_ready), 64'd1);
        @(posedge clk);
        #1;
        lat = 2;
        drive_req(16'd2, 16'd2, 16'd5, 4'd6, 1'b1);
        wait_accept("acc_after_rst");
        wait_drain("drain_after_rst");
        check("err_final", 64'(bus.err_tmo), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
